// File: rtl/char_plane_writer_pkg.sv
// Shared constants and types for the character plane writer.
// Used by the writer, System and PixelEncoder.
package char_plane_writer_pkg;

  localparam int ROW_NUMBER     = 16;
  localparam int COL_NUMBER     = 32;
  localparam int CHAR_ID_LENGTH = 8;
  localparam int ROW_BIT_LEN    = $clog2(ROW_NUMBER);
  localparam int COL_BIT_LEN    = $clog2(COL_NUMBER);
  localparam int CELL_BIT_LEN   = ROW_BIT_LEN + COL_BIT_LEN;

  typedef logic [ROW_BIT_LEN-1:0]    row_t;
  typedef logic [COL_BIT_LEN-1:0]    col_t;
  typedef logic [CHAR_ID_LENGTH-1:0] char_t;

  localparam char_t BLANK_ID = 8'h20;
  localparam char_t LF       = 8'h0A;
  localparam char_t CR       = 8'h0D;
  localparam char_t FF       = 8'h0C;
  localparam char_t BS       = 8'h08;
  localparam char_t PRINT_LO = 8'h20;
  localparam char_t PRINT_HI = 8'h7E;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADV,
    CUR_NL,
    CUR_CR,
    CUR_HOME,
    CUR_BACK
  } cur_op_t;

  function automatic logic is_printable(char_t c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/char_plane_writer_if.sv
// Byte stream into the character plane writer.
// valid/ready handshake, one byte per cycle.
interface char_plane_writer_if;
  import char_plane_writer_pkg::*;

  char_t in_char;
  logic  in_valid;
  logic  in_ready;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/char_plane_writer_cursor.sv
// Insertion cursor: advance, newline, CR, home, and retreat
// when CHAR_PLANE_BACKSPACE_EN is defined.
module char_cursor
  import char_plane_writer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  cur_op_t op,
  output row_t    row,
  output col_t    col
`ifdef CHAR_PLANE_BACKSPACE_EN
  ,
  output row_t    back_row,
  output col_t    back_col
`endif
);

  localparam col_t COL_LAST = col_t'(COL_NUMBER - 1);

  row_t row_nx;
  col_t col_nx;

`ifdef CHAR_PLANE_BACKSPACE_EN
  // Home cell is sticky: retreat from (0,0) stays put.
  always_comb begin
    back_row = row;
    back_col = col;
    if (col != '0) begin
      back_col = col - 1'b1;
    end else if (row != '0) begin
      back_col = COL_LAST;
      back_row = row - 1'b1;
    end
  end
`endif

  always_comb begin
    row_nx = row;
    col_nx = col;
    unique case (op)
      CUR_ADV: begin
        if (col == COL_LAST) begin
          col_nx = '0;
          row_nx = row + 1'b1;
        end else begin
          col_nx = col + 1'b1;
        end
      end
      CUR_NL: begin
        col_nx = '0;
        row_nx = row + 1'b1;
      end
      CUR_CR: col_nx = '0;
      CUR_HOME: begin
        row_nx = '0;
        col_nx = '0;
      end
`ifdef CHAR_PLANE_BACKSPACE_EN
      CUR_BACK: begin
        row_nx = back_row;
        col_nx = back_col;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nx;
      col <= col_nx;
    end
  end

endmodule

// File: rtl/char_plane_writer.sv
// Byte stream to CharacterPlane writes with a full-screen clear.
// CHAR_PLANE_BACKSPACE_EN enables 0x08 as erase-back.
module char_plane_writer
  import char_plane_writer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  char_plane_writer_if.slave  in_bus,
  input  logic                clear_req,
  output logic                busy,
  output logic                wr_en,
  output char_t               wr_char,
  output row_t                wr_row,
  output col_t                wr_col,
  output row_t                cursor_row,
  output col_t                cursor_col
);

  state_t                  state, state_nx;
  logic [CELL_BIT_LEN-1:0] clr_cnt;
  cur_op_t                 cur_op;
  logic                    take;
  logic                    wr_en_nx;
  char_t                   wr_char_nx;
  row_t                    wr_row_nx;
  col_t                    wr_col_nx;

`ifdef CHAR_PLANE_BACKSPACE_EN
  row_t back_row;
  col_t back_col;
`endif

  char_cursor u_cursor (
    .clk      (clk),
    .reset    (reset),
    .op       (cur_op),
    .row      (cursor_row),
    .col      (cursor_col)
`ifdef CHAR_PLANE_BACKSPACE_EN
    ,
    .back_row (back_row),
    .back_col (back_col)
`endif
  );

  assign in_bus.in_ready = (state == IDLE) && !clear_req;
  assign take = in_bus.in_valid && in_bus.in_ready;
  assign busy = (state == CLEAR);

  always_comb begin
    state_nx   = state;
    cur_op     = CUR_HOLD;
    wr_en_nx   = 1'b0;
    wr_char_nx = wr_char;
    wr_row_nx  = wr_row;
    wr_col_nx  = wr_col;
    unique case (state)
      CLEAR: begin
        wr_en_nx   = 1'b1;
        wr_char_nx = BLANK_ID;
        {wr_row_nx, wr_col_nx} = clr_cnt;
        if (&clr_cnt) begin
          state_nx = IDLE;
          cur_op   = CUR_HOME;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
        end else if (take) begin
          unique case (1'b1)
            is_printable(in_bus.in_char): begin
              wr_en_nx   = 1'b1;
              wr_char_nx = in_bus.in_char;
              wr_row_nx  = cursor_row;
              wr_col_nx  = cursor_col;
              cur_op     = CUR_ADV;
            end
            in_bus.in_char == LF: cur_op = CUR_NL;
            in_bus.in_char == CR: cur_op = CUR_CR;
            in_bus.in_char == FF: state_nx = CLEAR;
`ifdef CHAR_PLANE_BACKSPACE_EN
            in_bus.in_char == BS: begin
              wr_en_nx   = 1'b1;
              wr_char_nx = BLANK_ID;
              wr_row_nx  = back_row;
              wr_col_nx  = back_col;
              cur_op     = CUR_BACK;
            end
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  // Counter wraps 511 -> 0, so it is ready for the next clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_en   <= 1'b0;
      wr_char <= '0;
      wr_row  <= '0;
      wr_col  <= '0;
    end else begin
      state   <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      wr_en   <= wr_en_nx;
      wr_char <= wr_char_nx;
      wr_row  <= wr_row_nx;
      wr_col  <= wr_col_nx;
    end
  end

endmodule

// File: tb/tb_char_plane_writer.sv
// Self-checking bench for char_plane_writer: vector table,
// hand sequences, and a write scoreboard.
module tb_char_plane_writer;

  typedef struct packed {
    logic [3:0] r;
    logic [4:0] c;
    logic [7:0] ch;
  } wr_t;

  typedef struct packed {
    logic [7:0] ch;
    logic       wr;
    logic [3:0] wr_r;
    logic [4:0] wr_c;
    logic [7:0] wch;
    logic [3:0] cr;
    logic [4:0] cc;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       clear_req;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_char;
  logic [3:0] wr_row;
  logic [4:0] wr_col;
  logic [3:0] cursor_row;
  logic [4:0] cursor_col;

  char_plane_writer_if bus ();

  char_plane_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_bus     (bus),
    .clear_req  (clear_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_char    (wr_char),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  wr_t sb[$];
  vec_t tbl[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got r=%0d c=%0d ch=%0h expected none",
                 wr_row, wr_col, wr_char);
      end else begin
        e = sb.pop_front();
        if ({wr_row, wr_col, wr_char} !== e) begin
          errors++;
          $display("FAIL wr_data got r=%0d c=%0d ch=%0h expected r=%0d c=%0d ch=%0h",
                   wr_row, wr_col, wr_char, e.r, e.c, e.ch);
        end
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < 512; i++) begin
      wr_t w;
      w.r  = i[8:5];
      w.c  = i[4:0];
      w.ch = 8'h20;
      sb.push_back(w);
    end
  endtask

  task automatic wait_idle(input bit count_it);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy expected idle");
    end else if (count_it) begin
      chk("busy_cycles", n, 512);
    end
    @(posedge clk);
    #1;
    chk("clear_drain", sb.size(), 0);
    chk("idle_cur_row", cursor_row, 0);
    chk("idle_cur_col", cursor_col, 0);
    chk("idle_ready", bus.in_ready, 1);
  endtask

  task automatic apply(input vec_t v);
    wr_t w;
    bus.in_char  = v.ch;
    bus.in_valid = 1'b1;
    if (v.wr) begin
      w.r  = v.wr_r;
      w.c  = v.wr_c;
      w.ch = v.wch;
      sb.push_back(w);
    end
    @(negedge clk);
    chk("in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("cur_row", cursor_row, v.cr);
    chk("cur_col", cursor_col, v.cc);
  endtask

  function automatic vec_t mk(input logic [7:0] ch, input logic wr,
                              input logic [3:0] wr_r, input logic [4:0] wr_c,
                              input logic [7:0] wch, input logic [3:0] cr,
                              input logic [4:0] cc);
    vec_t v;
    v.ch = ch; v.wr = wr; v.wr_r = wr_r; v.wr_c = wr_c;
    v.wch = wch; v.cr = cr; v.cc = cc;
    return v;
  endfunction

  initial begin
    int base;
    bit hit;
    tbl[0]  = mk(8'h41, 1, 0, 0, 8'h41, 0, 1);
    tbl[1]  = mk(8'h42, 1, 0, 1, 8'h42, 0, 2);
    tbl[2]  = mk(8'h20, 1, 0, 2, 8'h20, 0, 3);
    tbl[3]  = mk(8'h7E, 1, 0, 3, 8'h7E, 0, 4);
    tbl[4]  = mk(8'h01, 0, 0, 0, 8'h00, 0, 4);
    tbl[5]  = mk(8'h7F, 0, 0, 0, 8'h00, 0, 4);
    tbl[6]  = mk(8'hFF, 0, 0, 0, 8'h00, 0, 4);
    tbl[7]  = mk(8'h1F, 0, 0, 0, 8'h00, 0, 4);
    tbl[8]  = mk(8'h0D, 0, 0, 0, 8'h00, 0, 0);
    tbl[9]  = mk(8'h0A, 0, 0, 0, 8'h00, 1, 0);
    tbl[10] = mk(8'h7A, 1, 1, 0, 8'h7A, 1, 1);

    reset = 1'b1;
    clear_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_char", wr_char, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_wr_col", wr_col, 0);
    chk("rst_cur", {cursor_row, cursor_col}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", bus.in_ready, 0);
    push_clear();
    reset = 1'b0;
    wait_idle(1);

    foreach (tbl[i]) apply(tbl[i]);
    bus.in_valid = 1'b0;

    // Form feed, with a clear_req pulse mid-clear that must be ignored.
    apply(mk(8'h0C, 0, 0, 0, 8'h00, 1, 1));
    bus.in_valid = 1'b0;
    chk("ff_busy", busy, 1);
    push_clear();
    repeat (5) @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    wait_idle(0);

    for (int k = 1; k <= 15; k++)
      apply(mk(8'h0A, 0, 0, 0, 8'h00, 4'(k), 0));
    for (int c = 0; c < 31; c++)
      apply(mk(8'h61, 1, 15, 5'(c), 8'h61, 15, 5'(c + 1)));
    apply(mk(8'h5A, 1, 15, 31, 8'h5A, 0, 0));
    for (int k = 1; k <= 16; k++)
      apply(mk(8'h0A, 0, 0, 0, 8'h00, 4'(k % 16), 0));
    bus.in_valid = 1'b0;

    // clear_req beats a simultaneous byte.
    clear_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_char = 8'h41;
    @(negedge clk);
    chk("clr_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_busy", busy, 1);
    push_clear();
    wait_idle(0);

    apply(mk(8'h0A, 0, 0, 0, 8'h00, 1, 0));
`ifdef CHAR_PLANE_BACKSPACE_EN
    apply(mk(8'h08, 1, 0, 31, 8'h20, 0, 31));
    apply(mk(8'h0D, 0, 0, 0, 8'h00, 0, 0));
    apply(mk(8'h08, 1, 0, 0, 8'h20, 0, 0));
`else
    apply(mk(8'h08, 0, 0, 0, 8'h00, 1, 0));
`endif
    bus.in_valid = 1'b0;

    // Reset at clear write 200 restarts the whole clear.
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    push_clear();
    reset = 1'b0;
    base = wr_cnt;
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (wr_cnt - base >= 200) hit = 1;
    end
    chk("mid_clear_reached", hit, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 1);
    push_clear();
    reset = 1'b0;
    wait_idle(1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_plane_writer.md
CHAR_PLANE_WRITER -- requirements
Module: char_plane_writer

Interface
REQ-001 Parameters: ROW_NUMBER 16, text rows; COL_NUMBER 32, cells per row; CHAR_ID_LENGTH 8, character id width; BLANK_ID 8'h20, id written by clears.
REQ-002 Ports: clk in 1, sole clock, all logic on rising edge.
REQ-003 Ports: reset in 1, synchronous active-high reset.
REQ-004 Ports: in_char in 8, incoming byte; in_valid in 1, byte present; in_ready out 1, byte accepted when in_valid&in_ready at clk edge.
REQ-005 Ports: clear_req in 1, single-cycle request to blank the screen; busy out 1, clear sequence in progress.
REQ-006 Ports: wr_en out 1, write strobe to CharacterPlane; wr_char out 8, id; wr_row out 4; wr_col out 5. All registered.
REQ-007 Ports: cursor_row out 4, cursor_col out 5, current insertion cell, registered.

Function
REQ-008 The FSM SHALL have states CLEAR and IDLE only.
REQ-009 CLEAR SHALL issue one write per cycle: wr_en=1, wr_char=BLANK_ID, {wr_row,wr_col}=clear counter 0..511 in row-major order; 512 cycles total.
REQ-010 After the write of cell (15,31), the FSM SHALL enter IDLE with cursor (0,0) on the next edge; busy=1 exactly while in CLEAR.
REQ-011 in_ready SHALL equal (state==IDLE) && !clear_req (combinational); throughput one byte per cycle.
REQ-012 Printable byte (0x20..0x7E) accepted at edge N SHALL produce wr_en=1, wr_char=byte, wr_row/wr_col=cursor-before-accept during cycle N+1; cursor advances at edge N.
REQ-013 Cursor advance: col+1; col 31 -> col 0, row+1; (15,31) -> (0,0); no scrolling.
REQ-014 0x0A (LF): col 0, row+1, row 15 wraps to 0, no write.
REQ-015 0x0D (CR): col 0, row unchanged, no write.
REQ-016 0x0C (FF): enter CLEAR on next edge, no write from the FF byte itself.
REQ-017 Bytes 0x00..0x1F not listed and 0x7F..0xFF SHALL be consumed (in_ready honoured) with no write and no cursor change.
REQ-018 clear_req in IDLE SHALL win over a simultaneous in_valid (byte not accepted) and enter CLEAR; clear_req in CLEAR SHALL be ignored.
REQ-019 wr_en SHALL be 0 in every cycle not specified above; wr_char/wr_row/wr_col hold last value when wr_en=0.

Reset
REQ-020 On reset: state=CLEAR, clear counter=0, cursor (0,0), wr_en=0, wr_char=0, wr_row=0, wr_col=0; first clear write appears cycle after reset deasserts.
REQ-021 Reset asserted mid-clear or mid-stream SHALL discard progress and restart the full 512-cell clear.

Configuration
REQ-022 Macro CHAR_PLANE_BACKSPACE_EN defined: 0x08 moves cursor back one cell (col-1; col 0 -> col 31, row-1; (0,0) stays (0,0)) and writes BLANK_ID to the new cursor cell next cycle.
REQ-023 Macro undefined: 0x08 handled per REQ-017.

Structure
REQ-024 Shared package holds ROW_NUMBER, COL_NUMBER, CHAR_ID_LENGTH, ROW_BIT_LEN, COL_BIT_LEN, BLANK_ID and control-code constants (LF, CR, FF, BS); System and PixelEncoder use the same package.
REQ-025 One sub-module char_cursor: holds cursor_row/cursor_col, implements advance, newline, CR, home and (under macro) retreat.

Verification
REQ-026 Release reset -> busy=1 512 cycles, wr_en=1 each cycle, last write (15,31) id 0x20, then in_ready=1, cursor (0,0).
REQ-027 Stream "AB" back-to-back -> writes (0,0)=0x41, (0,1)=0x42 on consecutive cycles, cursor (0,2).
REQ-028 Cursor (15,31), send 0x5A -> write (15,31)=0x5A, cursor (0,0); LF at row 15 -> cursor (0,0), no wr_en.
REQ-029 clear_req and in_valid with 0x41 same cycle in IDLE -> byte not accepted, busy=1 next cycle, no write of 0x41.
REQ-030 Reset at clear cycle 200 -> clear restarts at (0,0), 512 writes follow.
REQ-031 With CHAR_PLANE_BACKSPACE_EN, cursor (1,0), send 0x08 -> cursor (0,31), write (0,31)=0x20; without macro -> no write, cursor unchanged.
